// File: rtl/ahb_slave_arbiter_if.sv
// Bus bundle between the masters' request stages and the slave-port arbiter.
// The arbiter takes the slave modport; the request side takes the master modport.
interface ahb_slave_arbiter_if #(
  parameter int NM = 13
);
  logic [NM-1:0] req;
  logic [1:0]    htrans;
  logic [2:0]    hburst;
  logic          hmastlock;
  logic          hready;
  logic [NM-1:0] addr_sel;
  logic [NM-1:0] data_sel;
  logic [3:0]    hmaster;

  modport master (
    output req, htrans, hburst, hmastlock, hready,
    input  addr_sel, data_sel, hmaster
  );

  modport slave (
    input  req, htrans, hburst, hmastlock, hready,
    output addr_sel, data_sel, hmaster
  );
endinterface

// File: rtl/ahb_slave_arbiter.sv
// Round-robin arbiter for one AHB-Lite slave port; grants are held across bursts and locked sequences.
// Define AHB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotating pointer).
module ahb_slave_arbiter #(
  parameter int NM = 13
) (
  input  logic               hclk,
  input  logic               hresetn,
  ahb_slave_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  htrans_e       trans;
  logic [NM-1:0] addr_sel_q;
  logic [NM-1:0] data_sel_q;
  logic [3:0]    hmaster_q;
  logic [3:0]    cnt_q;
  logic [3:0]    cnt_load;
  logic          rearb;
  logic          gnt_found;
  logic [3:0]    gnt_idx;
  logic [NM-1:0] nxt_sel;
`ifndef AHB_ARB_FIXED_PRIO_EN
  logic [3:0]    ptr_q;
  logic [3:0]    ptr_nxt;
`endif

  assign trans = htrans_e'(bus.htrans);

  // A grant may only move when the current address phase completes and ends a transfer sequence.
  always_comb begin
    rearb = 1'b0;
    if (bus.hready && !bus.hmastlock) begin
      case (trans)
        TR_IDLE:   rearb = 1'b1;
        TR_NONSEQ: rearb = (bus.hburst == 3'b000);
        TR_SEQ:    rearb = (cnt_q == 4'd1);
        default:   rearb = 1'b0;
      endcase
    end
  end

  // Remaining SEQ beats after the NONSEQ of a fixed-length burst; WRAPx and INCRx alike.
  always_comb begin
    case (bus.hburst[2:1])
      2'b01:   cnt_load = 4'd3;
      2'b10:   cnt_load = 4'd7;
      2'b11:   cnt_load = 4'd15;
      default: cnt_load = 4'd0;
    endcase
  end

  always_comb begin
    int j;
    j         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    nxt_sel   = '0;
    for (int k = 0; k < NM; k++) begin
`ifdef AHB_ARB_FIXED_PRIO_EN
      j = k;
`else
      j = int'(ptr_q) + k;
      if (j >= NM) j = j - NM;
`endif
      if (!gnt_found && bus.req[j[3:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = j[3:0];
      end
    end
    if (gnt_found) nxt_sel[gnt_idx] = 1'b1;
  end

`ifndef AHB_ARB_FIXED_PRIO_EN
  assign ptr_nxt = (gnt_idx == 4'(NM - 1)) ? 4'd0 : gnt_idx + 4'd1;
`endif

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      addr_sel_q <= '0;
      data_sel_q <= '0;
      hmaster_q  <= '0;
      cnt_q      <= '0;
`ifndef AHB_ARB_FIXED_PRIO_EN
      ptr_q      <= '0;
`endif
    end else if (bus.hready) begin
      data_sel_q <= addr_sel_q;
      case (trans)
        TR_NONSEQ: cnt_q <= cnt_load;
        TR_SEQ:    if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        TR_IDLE:   cnt_q <= 4'd0;
        default:   ;
      endcase
      if (rearb) begin
        addr_sel_q <= nxt_sel;
        hmaster_q  <= gnt_idx;
`ifndef AHB_ARB_FIXED_PRIO_EN
        if (gnt_found) ptr_q <= ptr_nxt;
`endif
      end
    end
  end

  assign bus.addr_sel = addr_sel_q;
  assign bus.data_sel = data_sel_q;
  assign bus.hmaster  = hmaster_q;

endmodule
